// File: rtl/dual_port_ram_defines.sv
// Shared definitions for the dual-port RAM subsystem: port-B arbiter states,
// the default ownership bound and the contention winner rule.
`timescale 1ns/1ps
package dual_port_ram_defines;

  typedef enum logic [1:0] {
    ST_ARB_IDLE   = 2'd0,
    ST_ARB_ACCESS = 2'd1,
    ST_ARB_HOLD   = 2'd2
  } dpram_arb_estado_t;

  localparam int unsigned DPRAM_ARB_TIMEOUT_CYC = 16;

  // A lone requester wins; under contention the one that did not own last wins.
  function automatic logic arb_pick(input logic [1:0] req, input logic last_owner);
    if (req == 2'b11) return ~last_owner;
    return req[1];
  endfunction

endpackage

// File: rtl/dpram_arb_timeout_counter.sv
// Counts consecutive owned cycles; expire_o is high during the owned cycle that
// completes TIMEOUT_CYC cycles. clear_i (grant) restarts the count.
`timescale 1ns/1ps
module dpram_arb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Two-requester owner arbiter for RAM port B; each access is acked one cycle later, lock holds ownership.
// Define DPRAM_ARB_TIMEOUT_EN to bound ownership to TIMEOUT_CYC cycles (timeout_o pulses on forced release).
`timescale 1ns/1ps
module dpram_port_arbiter
  import dual_port_ram_defines::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = DPRAM_ARB_TIMEOUT_CYC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        lock_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [1:0]        we_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              timeout_o
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("dpram_port_arbiter: TIMEOUT_CYC must be at least 1");
  end

  dpram_arb_estado_t state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [1:0]        ack_q, ack_d;
  logic              rd_pend_q, rd_pend_d;
  logic              access;
  logic              expire;

`ifdef DPRAM_ARB_TIMEOUT_EN
  dpram_arb_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  ((state_q == ST_ARB_IDLE) && (req_i != 2'b00)),
    .en_i     (state_q != ST_ARB_IDLE),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign timeout_o = expire;
  assign access    = (state_q == ST_ARB_ACCESS) && req_i[owner_q];
  assign ram_en_o  = access;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_o        = 2'b00;
    ram_we_o     = 1'b0;
    ram_addr_o   = '0;
    ram_wdata_o  = '0;

    unique case (state_q)
      ST_ARB_IDLE: begin
        if (req_i != 2'b00) begin
          state_d = ST_ARB_ACCESS;
          owner_d = arb_pick(req_i, last_owner_q);
        end
      end
      ST_ARB_ACCESS: begin
        gnt_o[owner_q] = 1'b1;
        ram_we_o       = we_i[owner_q];
        ram_addr_o     = owner_q ? addr1_i : addr0_i;
        ram_wdata_o    = owner_q ? wdata1_i : wdata0_i;
        if (!req_i[owner_q]) begin
          state_d = lock_i[owner_q] ? ST_ARB_HOLD : ST_ARB_IDLE;
        end
      end
      ST_ARB_HOLD: begin
        gnt_o[owner_q] = 1'b1;
        if (req_i[owner_q]) begin
          state_d = ST_ARB_ACCESS;
        end else if (!lock_i[owner_q]) begin
          state_d = ST_ARB_IDLE;
        end
      end
      default: state_d = ST_ARB_IDLE;
    endcase

    if (expire) begin
      state_d = ST_ARB_IDLE;
    end
    // Fairness memory is updated on every release, voluntary or forced.
    if ((state_d == ST_ARB_IDLE) && (state_q != ST_ARB_IDLE)) begin
      last_owner_d = owner_q;
    end
  end

  always_comb begin
    ack_d          = 2'b00;
    ack_d[owner_q] = access;
    rd_pend_d      = access && !we_i[owner_q];
  end

  assign ack_o   = ack_q;
  assign rdata_o = rd_pend_q ? ram_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_ARB_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      ack_q        <= 2'b00;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ack_q        <= ack_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed scenarios plus a randomized run against a reference model.
`timescale 1ns/1ps
module tb_dpram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 16;
`ifdef DPRAM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [1:0]    req_i = '0, lock_i = '0, we_i = '0;
  logic [AW-1:0] addr0_i = '0, addr1_i = '0;
  logic [DW-1:0] wdata0_i = '0, wdata1_i = '0;
  logic [1:0]    gnt_o, ack_o;
  logic [DW-1:0] rdata_o, ram_wdata_o;
  logic          ram_en_o, ram_we_o, timeout_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_rdata_i = '0;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_dat = '0;
  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  dpram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .we_i(we_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .rdata_o(rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // RAM port B with 1-cycle read latency; contents are re-seeded while in reset.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_dat;
    end else if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      else ram_rdata_i <= mem[ram_addr_o];
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = '0; lock_i = '0; we_i = '0;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    idle_inputs();
    req_i = 2'b11; we_i = 2'b11; addr0_i = 8'hFF; wdata0_i = 16'hFFFF;
    tick(); tick(); #3;
    checks++;
    if ({gnt_o, ack_o, rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b ack=%b rdata=%h en=%b we=%b addr=%h wdata=%h to=%b, all required 0",
               gnt_o, ack_o, rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, timeout_o);
    end
    idle_inputs();
    tick(); rst_i = 1'b1; #3;
    checks++;
    if ({gnt_o, ack_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: gnt=%b ack=%b, required 00 00", gnt_o, ack_o);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    tick(); pre_we = 1'b1; pre_addr = 8'h10; pre_dat = 16'h1234; #3;
    tick(); pre_we = 1'b0; req_i = 2'b01; we_i = 2'b00; addr0_i = 8'h10; #3;
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++; $display("FAIL read_req_cycle_gnt: gnt=%b required 00", gnt_o);
    end
    tick(); #3;
    checks++;
    if ({gnt_o, ram_en_o, ram_we_o, ram_addr_o, ack_o} !== {2'b01, 1'b1, 1'b0, 8'h10, 2'b00}) begin
      errors++;
      $display("FAIL read_grant: gnt=%b en=%b we=%b addr=%h ack=%b, required 01 1 0 10 00",
               gnt_o, ram_en_o, ram_we_o, ram_addr_o, ack_o);
    end
    tick(); req_i = 2'b00; #3;
    checks++;
    if ({ack_o, rdata_o} !== {2'b01, 16'h1234}) begin
      errors++; $display("FAIL read_ack: ack=%b rdata=%h, required 01 1234", ack_o, rdata_o);
    end
    tick(); #3;
    checks++;
    if ({gnt_o, ack_o, rdata_o} !== '0) begin
      errors++; $display("FAIL read_after: gnt=%b ack=%b rdata=%h, required 0", gnt_o, ack_o, rdata_o);
    end
  endtask

  task automatic test_contention();
    do_reset();
    tick(); req_i = 2'b11; we_i = 2'b00; addr0_i = 8'h20; addr1_i = 8'h21; #3;
    tick(); #3;
    checks++;
    if ({gnt_o, ram_addr_o} !== {2'b01, 8'h20}) begin
      errors++; $display("FAIL cont_first_win: gnt=%b addr=%h, required 01 20", gnt_o, ram_addr_o);
    end
    tick(); req_i = 2'b10; #3;
    checks++;
    if ({gnt_o, ack_o} !== {2'b01, 2'b01}) begin
      errors++; $display("FAIL cont_owner_drop: gnt=%b ack=%b, required 01 01", gnt_o, ack_o);
    end
    tick(); #3;
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++; $display("FAIL cont_idle_gap: gnt=%b required 00", gnt_o);
    end
    tick(); #3;
    checks++;
    if ({gnt_o, ram_en_o, ram_addr_o} !== {2'b10, 1'b1, 8'h21}) begin
      errors++; $display("FAIL cont_second: gnt=%b en=%b addr=%h, required 10 1 21", gnt_o, ram_en_o, ram_addr_o);
    end
    tick(); req_i = 2'b00; #3;
    checks++;
    if (ack_o !== 2'b10) begin
      errors++; $display("FAIL cont_second_ack: ack=%b required 10", ack_o);
    end
    tick(); req_i = 2'b11; #3;
    tick(); #3;
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++; $display("FAIL cont_alternate: gnt=%b required 01", gnt_o);
    end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_hold();
    do_reset();
    tick(); req_i = 2'b10; we_i = 2'b10; lock_i = 2'b10; addr1_i = 8'h05; wdata1_i = 16'hBEEF; #3;
    tick(); #3;
    checks++;
    if ({gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o} !== {2'b10, 1'b1, 1'b1, 8'h05, 16'hBEEF}) begin
      errors++;
      $display("FAIL hold_write: gnt=%b en=%b we=%b addr=%h wdata=%h, required 10 1 1 05 beef",
               gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      req_i = (c == 5) ? 2'b11 : 2'b01;
      if (c == 5) we_i = 2'b00;
      #3;
      checks++;
      if ({gnt_o, ram_en_o, ack_o} !== {2'b10, 1'b0, (c == 2) ? 2'b10 : 2'b00}) begin
        errors++; $display("FAIL hold_cycle%0d: gnt=%b en=%b ack=%b, required gnt 10 en 0", c, gnt_o, ram_en_o, ack_o);
      end
    end
    tick(); #3;
    checks++;
    if ({gnt_o, ram_en_o, ram_we_o, ram_addr_o} !== {2'b10, 1'b1, 1'b0, 8'h05}) begin
      errors++; $display("FAIL hold_read: gnt=%b en=%b we=%b addr=%h, required 10 1 0 05", gnt_o, ram_en_o, ram_we_o, ram_addr_o);
    end
    tick(); req_i = 2'b01; lock_i = 2'b00; #3;
    checks++;
    if ({gnt_o, ack_o, rdata_o} !== {2'b10, 2'b10, 16'hBEEF}) begin
      errors++; $display("FAIL hold_read_ack: gnt=%b ack=%b rdata=%h, required 10 10 beef", gnt_o, ack_o, rdata_o);
    end
    tick(); #3;
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++; $display("FAIL hold_release: gnt=%b required 00", gnt_o);
    end
    tick(); #3;
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++; $display("FAIL hold_waiter_grant: gnt=%b required 01", gnt_o);
    end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(); req_i = 2'b01; we_i = 2'b01; addr0_i = 8'h30; wdata0_i = 16'hA000; #3;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        addr0_i = 8'(8'h30 + c - 1); wdata0_i = 16'(16'hA000 + c - 1);
      end else begin
        req_i = 2'b00;
      end
      #3;
      checks++;
      if ({ack_o, ram_en_o} !== {(c >= 2 && c <= 5) ? 2'b01 : 2'b00, c <= 4}) begin
        errors++; $display("FAIL b2b_cycle%0d: ack=%b en=%b", c, ack_o, ram_en_o);
      end
      if (c <= 4) begin
        checks++;
        if ({ram_addr_o, ram_wdata_o} !== {8'(8'h30 + c - 1), 16'(16'hA000 + c - 1)}) begin
          errors++; $display("FAIL b2b_addr%0d: addr=%h wdata=%h", c, ram_addr_o, ram_wdata_o);
        end
      end
    end
    checks++;
    if (mem[8'h33] !== 16'hA003) begin
      errors++; $display("FAIL b2b_ram_content: mem[33]=%h required a003", mem[8'h33]);
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    tick(); req_i = 2'b01; we_i = 2'b00; addr0_i = 8'h10; #3;
    tick(); #3;
    checks++;
    if (ram_en_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_access: en=%b required 1", ram_en_o);
    end
    tick(); rst_i = 1'b0; req_i = 2'b00; #3;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({gnt_o, ack_o, rdata_o, ram_en_o, timeout_o} !== '0) begin
        errors++; $display("FAIL rstmid_in_reset%0d: gnt=%b ack=%b rdata=%h en=%b", c, gnt_o, ack_o, rdata_o, ram_en_o);
      end
      tick(); #3;
    end
    rst_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick(); #3;
      checks++;
      if ({gnt_o, ack_o} !== 4'b0000) begin
        errors++; $display("FAIL rstmid_release%0d: gnt=%b ack=%b, required 00 00", c, gnt_o, ack_o);
      end
    end
    req_i = 2'b01; tick(); #3;
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++; $display("FAIL rstmid_regrant: gnt=%b required 01", gnt_o);
    end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_ownership_bound();
    int last_c;
    last_c = TO_EN ? TO : 40;
    do_reset();
    tick(); req_i = 2'b01; lock_i = 2'b01; we_i = 2'b00; #3;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      if (c == 2) req_i = 2'b10;
      #3;
      checks++;
      if ({gnt_o, timeout_o} !== {2'b01, TO_EN && (c == TO)}) begin
        errors++; $display("FAIL bound_cycle%0d: gnt=%b timeout=%b", c, gnt_o, timeout_o);
      end
    end
    if (!TO_EN) lock_i = 2'b00;
    tick(); #3;
    checks++;
    if ({gnt_o, timeout_o} !== 3'b000) begin
      errors++; $display("FAIL bound_release: gnt=%b timeout=%b, required 00 0", gnt_o, timeout_o);
    end
    tick(); #3;
    checks++;
    if (gnt_o !== 2'b10) begin
      errors++; $display("FAIL bound_other_grant: gnt=%b required 10", gnt_o);
    end
    idle_inputs(); tick(); tick();
  endtask

  task automatic test_random();
    int m_own, m_last, m_cnt, a_port;
    bit m_act, a_rd, o_we, exp_en, exp_to, rel;
    logic [DW-1:0] a_dat, o_dat, exp_rd;
    logic [AW-1:0] o_addr;
    logic [1:0] exp_gnt, exp_ack, acc_prev;
    logic [DW-1:0] m_mem [256];
    do_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    m_own = -1; m_act = 0; m_last = 1; m_cnt = 0; a_port = -1; a_rd = 0; a_dat = '0;
    acc_prev = 2'b11;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!req_i[k] || acc_prev[k]) begin
          we_i[k] = 1'($urandom_range(0, 1));
          if (k == 0) begin
            addr0_i = 8'($urandom_range(0, 15)); wdata0_i = 16'($urandom);
          end else begin
            addr1_i = 8'($urandom_range(0, 15)); wdata1_i = 16'($urandom);
          end
        end
        req_i[k]  = ($urandom_range(0, 3) != 0);
        lock_i[k] = 1'($urandom_range(0, 1));
      end
      #3;
      exp_gnt = (m_own < 0) ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10);
      exp_en  = (m_own >= 0) && m_act && req_i[m_own];
      exp_to  = TO_EN && (m_own >= 0) && (m_cnt + 1 >= TO);
      exp_ack = (a_port < 0) ? 2'b00 : (a_port == 0 ? 2'b01 : 2'b10);
      exp_rd  = (a_port >= 0 && a_rd) ? a_dat : '0;
      o_addr  = (m_own == 1) ? addr1_i : addr0_i;
      o_dat   = (m_own == 1) ? wdata1_i : wdata0_i;
      o_we    = (m_own == 1) ? we_i[1] : we_i[0];
      checks++;
      if ({gnt_o, ram_en_o, timeout_o} !== {exp_gnt, exp_en, exp_to}) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d: gnt=%b en=%b to=%b, required %b %b %b",
                 cyc, gnt_o, ram_en_o, timeout_o, exp_gnt, exp_en, exp_to);
      end
      checks++;
      if ({ack_o, rdata_o} !== {exp_ack, exp_rd}) begin
        errors++;
        $display("FAIL rand_ack cyc%0d: ack=%b rdata=%h, required %b %h", cyc, ack_o, rdata_o, exp_ack, exp_rd);
      end
      if (exp_en) begin
        checks++;
        if ({ram_we_o, ram_addr_o, ram_wdata_o} !== {o_we, o_addr, o_dat}) begin
          errors++;
          $display("FAIL rand_ram cyc%0d: we=%b addr=%h wdata=%h, required %b %h %h",
                   cyc, ram_we_o, ram_addr_o, ram_wdata_o, o_we, o_addr, o_dat);
        end
      end
      acc_prev = 2'b00;
      if (exp_en) begin
        acc_prev[m_own] = 1'b1;
        a_port = m_own; a_rd = !o_we; a_dat = m_mem[o_addr];
        if (o_we) m_mem[o_addr] = o_dat;
      end else begin
        a_port = -1;
      end
      if (m_own < 0) begin
        if (req_i != 2'b00) begin
          m_own = (req_i == 2'b11) ? 1 - m_last : (req_i[1] ? 1 : 0);
          m_act = 1; m_cnt = 0;
        end
      end else begin
        m_cnt++;
        rel = 0;
        if (exp_to) rel = 1;
        else if (m_act) begin
          if (!req_i[m_own]) begin
            if (lock_i[m_own]) m_act = 0;
            else rel = 1;
          end
        end else begin
          if (req_i[m_own]) m_act = 1;
          else if (!lock_i[m_own]) rel = 1;
        end
        if (rel) begin
          m_last = m_own; m_own = -1;
        end
      end
    end
    idle_inputs(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_hold();
    test_back_to_back();
    test_reset_mid_access();
    test_ownership_bound();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
